button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
Input-conditioning stage directly upstream of the sudoku top-level game logic. Synchronises, debounces and edge-detects the seven raw active-high push-buttons (a, b, up, down, left, right, start). Emits one-clock press pulses, which the game FSMs consume as single actions. Optionally generates auto-repeat pulses for held directional buttons, for fast cursor movement across the 9x9 board.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronised input must differ from its stable state before the stable state flips (20 ms at 50 MHz)
REPEAT_DELAY, 25000000, cycles from a directional press pulse to the first repeat pulse (used only with AUTO_REPEAT_EN)
REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses (used only with AUTO_REPEAT_EN)

Ports:
clk_50MHz  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
a_raw, b_raw, up_raw, down_raw, left_raw, right_raw, start_raw  input  1 each  raw button levels, 1 = pressed, asynchronous to clk
a_button, b_button, up_button, down_button, left_button, right_button, start_button  output  1 each  one-cycle press pulses to game logic
held  output  7  debounced stable levels {start,right,left,down,up,b,a}, bit 0 = a
any_press  output  1  OR of the seven pulse outputs, same cycle

Behaviour:
- Reset (reset=0, asynchronous): sync flops, stable states, counters and repeat timers cleared. All pulse outputs, held and any_press are 0 while reset is low and on the first edge after release.
- Per button, identical and independent: 2-flop synchroniser (s1, s2); debounce counter, width $clog2(DEBOUNCE_CYCLES+1).
- Counter rule each edge: if s2 == stable, counter <= 0. Otherwise, if counter == DEBOUNCE_CYCLES-1, then stable <= s2 and counter <= 0; otherwise counter <= counter+1.
- Press pulse is registered high for exactly one cycle, on the edge where stable goes 0->1. Release (1->0) produces no pulse.
- Latency: raw held high from before edge k with stable=0 -> pulse high after edge k+1+DEBOUNCE_CYCLES, low after the next edge.
- Glitch shorter than DEBOUNCE_CYCLES synchronised cycles: counter restarts, no pulse, held unchanged.
- Simultaneous presses: all qualifying pulses assert in the same cycle with no arbitration. The game logic resolves priority.
- Button held through reset release: stable starts at 0, so one pulse is produced after the normal debounce latency.
- Reset asserted mid-debounce or mid-repeat: all state aborted. No pulse is emitted during or immediately after reset.
- No wrap-around possible: the counter saturates by design at DEBOUNCE_CYCLES-1 before clearing.

Optional Feature:
AUTO_REPEAT_EN defined:
- up/down/left/right each get a repeat timer, width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1).
- The timer is loaded at the press pulse.
- While stable stays 1, an extra one-cycle pulse is emitted REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles.
- Stable dropping to 0 clears the timer immediately and stops further pulses, including any pulse due that same cycle.
- a, b and start never repeat.
- any_press includes repeat pulses.

AUTO_REPEAT_EN undefined:
- No repeat logic is instantiated; exactly one pulse per debounced press.

Test Plan:
(All with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, clock period 4 time units.)
- Reset: hold reset=0 with all raw=1 -> all outputs 0. Release reset -> start_button pulses once, exactly 1 cycle wide, 6 edges after release; held[6]=1.
- Clean press: start_raw 0->1 held 20 cycles -> single start_button pulse 1+DEBOUNCE_CYCLES+1 edges after the first high sample, any_press coincident. Release -> no pulse; held[6] drops after debounce.
- Glitch: down_raw high for 3 cycles then low -> no down_button pulse, held[2] stays 0.
- Simultaneous: a_raw and right_raw rise on the same cycle -> a_button and right_button pulse in the same cycle, any_press=1 for that single cycle.
- Reset mid-operation: up_raw high, reset pulsed low 2 cycles after the rising edge -> no up_button pulse before the reset release. After release, up_button pulses once, 6 edges later.
- AUTO_REPEAT_EN: left_raw held 30 cycles -> left_button pulses at press P, P+10, P+13, P+16, ... until release; none after stable drops. With the macro undefined, only the pulse at P.

Source files
------------

// File: rtl/button_conditioner.sv
// Button conditioner: 2-flop sync, debounce and press-pulse generation for seven buttons.
// Define AUTO_REPEAT_EN to add auto-repeat pulses on held up/down/left/right buttons.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       a_raw,
  input  logic       b_raw,
  input  logic       up_raw,
  input  logic       down_raw,
  input  logic       left_raw,
  input  logic       right_raw,
  input  logic       start_raw,
  output logic       a_button,
  output logic       b_button,
  output logic       up_button,
  output logic       down_button,
  output logic       left_button,
  output logic       right_button,
  output logic       start_button,
  output logic [6:0] held,
  output logic       any_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("button_conditioner: all cycle parameters must be at least 1");
  end

  logic [6:0]       w_raw;
  logic [6:0]       r_s1;
  logic [6:0]       r_s2;
  logic [6:0]       r_stable;
  logic [6:0]       r_press;
  logic [6:0]       w_flip;
  logic [6:0]       w_pulse;
  logic [CNT_W-1:0] r_cnt [7];

  assign w_raw = {start_raw, right_raw, left_raw, down_raw, up_raw, b_raw, a_raw};

  // Stable level flips once s2 has disagreed with it for DEBOUNCE_CYCLES edges in a row
  always_comb begin
    w_flip = '0;
    for (int i = 0; i < 7; i++) begin
      w_flip[i] = (r_s2[i] != r_stable[i]) && (r_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1));
    end
  end

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_stable <= '0;
      r_press  <= '0;
      for (int i = 0; i < 7; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
      for (int i = 0; i < 7; i++) begin
        if (r_s2[i] == r_stable[i] || w_flip[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
        if (w_flip[i]) begin
          r_stable[i] <= r_s2[i];
        end
        r_press[i] <= w_flip[i] & r_s2[i];
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W   = $clog2(RPT_MAX + 1);

  // Index j covers directional buttons up/down/left/right (held bits 2..5)
  logic [TMR_W-1:0] r_tmr [4];
  logic [3:0]       r_rpt;
  logic [3:0]       w_fire;

  always_comb begin
    w_fire = '0;
    for (int j = 0; j < 4; j++) begin
      w_fire[j] = r_stable[j+2] && !w_flip[j+2] && (r_tmr[j] == '0);
    end
  end

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      r_rpt <= '0;
      for (int j = 0; j < 4; j++) begin
        r_tmr[j] <= '0;
      end
    end else begin
      r_rpt <= w_fire;
      for (int j = 0; j < 4; j++) begin
        if (w_flip[j+2] && r_s2[j+2]) begin
          r_tmr[j] <= TMR_W'(REPEAT_DELAY - 1);
        end else if (!r_stable[j+2] || w_flip[j+2]) begin
          r_tmr[j] <= '0;
        end else if (w_fire[j]) begin
          r_tmr[j] <= TMR_W'(REPEAT_PERIOD - 1);
        end else begin
          r_tmr[j] <= r_tmr[j] - 1'b1;
        end
      end
    end
  end

  assign w_pulse = r_press | {1'b0, r_rpt, 2'b00};
`else
  assign w_pulse = r_press;
`endif

  assign a_button     = w_pulse[0];
  assign b_button     = w_pulse[1];
  assign up_button    = w_pulse[2];
  assign down_button  = w_pulse[3];
  assign left_button  = w_pulse[4];
  assign right_button = w_pulse[5];
  assign start_button = w_pulse[6];
  assign held         = r_stable;
  assign any_press    = |w_pulse;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus randomized button activity.
module tb_button_conditioner;
  localparam int D   = 4;
  localparam int DL  = 10;
  localparam int PER = 3;

  logic clk_50MHz = 1'b0;
  always #2 clk_50MHz = ~clk_50MHz;

  logic reset;
  logic a_raw, b_raw, up_raw, down_raw, left_raw, right_raw, start_raw;
  logic a_button, b_button, up_button, down_button, left_button, right_button, start_button;
  logic [6:0] held;
  logic any_press;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (DL),
    .REPEAT_PERIOD  (PER)
  ) dut (
    .clk_50MHz   (clk_50MHz),
    .reset       (reset),
    .a_raw       (a_raw),
    .b_raw       (b_raw),
    .up_raw      (up_raw),
    .down_raw    (down_raw),
    .left_raw    (left_raw),
    .right_raw   (right_raw),
    .start_raw   (start_raw),
    .a_button    (a_button),
    .b_button    (b_button),
    .up_button   (up_button),
    .down_button (down_button),
    .left_button (left_button),
    .right_button(right_button),
    .start_button(start_button),
    .held        (held),
    .any_press   (any_press)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: raw history per edge, stable level, edge of last press per button
  logic [6:0] hist[$];
  logic [6:0] m_stable;
  logic [6:0] m_exp;
  int         e;
  int         m_pe[7];

  function automatic logic [6:0] raw_vec();
    return {start_raw, right_raw, left_raw, down_raw, up_raw, b_raw, a_raw};
  endfunction

  function automatic logic [6:0] dut_pulses();
    return {start_button, right_button, left_button, down_button, up_button, b_button, a_button};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    m_stable = '0;
    m_exp    = '0;
    e        = 0;
    for (int b = 0; b < 7; b++) m_pe[b] = -1;
  endtask

  // Synchronised value seen before edge t is the raw level sampled at edge t-2;
  // the stable level flips at edge e when the last D such values all disagree with it.
  task automatic model_step(input logic [6:0] raw);
    logic [6:0] new_st, press, fall, rpt, smp;
    bit         all_diff;
    logic       v;
    int         idx;
    e++;
    hist.push_back(raw);
    new_st = m_stable;
    press  = '0;
    fall   = '0;
    rpt    = '0;
    for (int b = 0; b < 7; b++) begin
      all_diff = 1'b1;
      for (int t = e - D + 1; t <= e; t++) begin
        idx = t - 2;
        v   = 1'b0;
        if (idx >= 1) begin
          smp = hist[idx-1];
          v   = smp[b];
        end
        if (v == m_stable[b]) all_diff = 1'b0;
      end
      if (all_diff) begin
        new_st[b] = ~m_stable[b];
        if (new_st[b]) press[b] = 1'b1;
        else           fall[b]  = 1'b1;
      end
    end
`ifdef AUTO_REPEAT_EN
    for (int b = 2; b <= 5; b++) begin
      if (m_stable[b] && !fall[b] && m_pe[b] >= 0 && (e - m_pe[b]) >= DL &&
          ((e - m_pe[b] - DL) % PER) == 0)
        rpt[b] = 1'b1;
    end
`endif
    for (int b = 0; b < 7; b++) if (press[b]) m_pe[b] = e;
    m_stable = new_st;
    m_exp    = press | rpt;
  endtask

  task automatic tick();
    @(posedge clk_50MHz);
    if (reset) model_step(raw_vec());
    else       model_clear();
    #1;
    check("pulses", {1'b0, dut_pulses()}, {1'b0, m_exp});
    check("held", {1'b0, held}, {1'b0, m_stable});
    check("any_press", {7'b0, any_press}, {7'b0, |m_exp});
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    model_clear();
    #1;
    check("rst_pulses", {1'b0, dut_pulses()}, 8'h00);
    check("rst_held", {1'b0, held}, 8'h00);
    check("rst_any", {7'b0, any_press}, 8'h00);
  endtask

  task automatic set_raw(input logic [6:0] v);
    {start_raw, right_raw, left_raw, down_raw, up_raw, b_raw, a_raw} = v;
  endtask

  int cnt;

  initial begin
    reset = 1'b1;
    set_raw(7'h7f);
    #1;
    // Reset held with every button pressed, then release
    assert_reset();
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("rst_start_lat", {7'b0, start_button}, {7'b0, (i == 6)});
    end
    check("rst_held6", {7'b0, held[6]}, 8'h01);

    set_raw(7'h00);
    assert_reset();
    for (int i = 0; i < 2; i++) tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Clean press and release of start
    start_raw = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("press_lat", {7'b0, start_button}, {7'b0, (i == 6)});
      check("press_any", {7'b0, any_press}, {7'b0, (i == 6)});
    end
    start_raw = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      cnt += int'(start_button);
    end
    check("release_nopulse", 8'(cnt), 8'd0);
    check("release_held", {7'b0, held[6]}, 8'h00);

    // Glitch on down shorter than the debounce window
    down_raw = 1'b1;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      cnt += int'(down_button);
    end
    down_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      cnt += int'(down_button);
    end
    check("glitch_nopulse", 8'(cnt), 8'd0);
    check("glitch_held", {7'b0, held[2]}, 8'h00);

    // Simultaneous a + right
    a_raw = 1'b1;
    right_raw = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("sim_a", {7'b0, a_button}, {7'b0, (i == 6)});
      check("sim_right", {7'b0, right_button}, {7'b0, (i == 6)});
      check("sim_any", {7'b0, any_press}, {7'b0, (i == 6)});
    end
    a_raw = 1'b0;
    right_raw = 1'b0;
    for (int i = 0; i < 12; i++) tick();

    // Reset pulsed mid-debounce of up
    up_raw = 1'b1;
    tick();
    tick();
    assert_reset();
    for (int i = 0; i < 2; i++) begin
      tick();
      check("midrst_up", {7'b0, up_button}, 8'h00);
    end
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("midrst_up_lat", {7'b0, up_button}, {7'b0, (i == 6)});
    end
    up_raw = 1'b0;
    for (int i = 0; i < 12; i++) tick();

    // Left held 30 cycles: press plus repeats only when the feature is built in
    left_raw = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      cnt += int'(left_button);
    end
    left_raw = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      cnt += int'(left_button);
    end
`ifdef AUTO_REPEAT_EN
    check("left_repeat_count", 8'(cnt), 8'd8);
`else
    check("left_repeat_count", 8'(cnt), 8'd1);
`endif

    // Randomized button activity with a reset in the middle
    for (int c = 0; c < 800; c++) begin
      logic [6:0] r;
      r = raw_vec();
      for (int b = 0; b < 7; b++) begin
        if ($urandom_range(0, 11) == 0) r[b] = ~r[b];
      end
      set_raw(r);
      if (c == 400) begin
        assert_reset();
        tick();
        tick();
        reset = 1'b1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
